score_display_driver: RTL and testbench

SCORE_DISPLAY_DRIVER -- requirements
Module: score_display_driver

---
 rtl/score_display_if.sv | 31 +++
 rtl/score_display_driver.sv | 128 ++++++++++++
 tb/tb_score_display_driver.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/score_display_if.sv
// score_display_if
//   Groups the score/display signals of score_display_driver.
//   master: drives SCORE_IN, LOAD and DOT_MASK, and observes the display outputs.
//   slave : the driver itself.
//   Signals:
//     SCORE_IN[13:0]      unsigned score to capture
//     LOAD                capture request, sampled every edge
//     DOT_MASK[3:0]       bit i lights the decimal point of digit i
//     BUSY                conversion in progress
//     SEG_SELECT_OUT[1:0] active digit (0 = units, 3 = thousands)
//     BIN_OUT[3:0]        BCD value of the active digit
//     DOT_OUT             decimal point of the active digit, 0 = lit
interface score_display_if;
    logic [13:0] SCORE_IN;
    logic        LOAD;
    logic [3:0]  DOT_MASK;
    logic        BUSY;
    logic [1:0]  SEG_SELECT_OUT;
    logic [3:0]  BIN_OUT;
    logic        DOT_OUT;

    modport master (
        output SCORE_IN, LOAD, DOT_MASK,
        input  BUSY, SEG_SELECT_OUT, BIN_OUT, DOT_OUT
    );

    modport slave (
        input  SCORE_IN, LOAD, DOT_MASK,
        output BUSY, SEG_SELECT_OUT, BIN_OUT, DOT_OUT
    );
endinterface

// File: rtl/score_display_driver.sv
// score_display_driver
//   Captures a 14-bit binary score, clamps it to 9999, converts it to four BCD
//   digits with a sequential double-dabble (one shift per cycle, 14 cycles),
//   and time-multiplexes the digits onto a single registered digit output.
//   Ports:
//     CLK    : system clock, rising edge
//     RESETN : synchronous active-low reset
//     bus    : score_display_if.slave (SCORE_IN, LOAD, DOT_MASK in;
//              BUSY, SEG_SELECT_OUT, BIN_OUT, DOT_OUT out)
//   Parameter:
//     REFRESH_DIV : clock cycles each digit is shown (>= 2)
module score_display_driver #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic           CLK,
    input  logic           RESETN,
    score_display_if.slave bus
);

    localparam int              PW        = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(REFRESH_DIV - 1);
    localparam logic [3:0]      LAST_STEP = 4'd13;

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t      state_q, state_d;
    logic [13:0] work_bin_q, work_bin_d;   // binary bits still to shift in
    logic [15:0] work_bcd_q, work_bcd_d;   // partial BCD result
    logic [3:0]  step_q, step_d;           // shifts completed so far
    logic [15:0] disp_q, disp_d;           // committed digits, shown by the scanner

    logic [PW-1:0] presc_q, presc_d;
    logic [1:0]    scan_q, scan_d;
    logic [1:0]    seg_q;
    logic [3:0]    digit_q;
    logic          dot_q;

    logic [15:0] bcd_adj;
    logic [29:0] shifted;
    logic [13:0] score_clamped;

    assign score_clamped = (bus.SCORE_IN > 14'd9999) ? 14'd9999 : bus.SCORE_IN;

    // One double-dabble step: bias every nibble >= 5 by 3, then shift the
    // concatenated BCD:binary word left by one.
    always_comb begin
        bcd_adj = work_bcd_q;
        for (int i = 0; i < 4; i++) begin
            if (work_bcd_q[i*4 +: 4] >= 4'd5)
                bcd_adj[i*4 +: 4] = work_bcd_q[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, work_bin_q} << 1;
    end

    always_comb begin
        state_d    = state_q;
        work_bin_d = work_bin_q;
        work_bcd_d = work_bcd_q;
        step_d     = step_q;
        disp_d     = disp_q;
        case (state_q)
            IDLE: begin
                if (bus.LOAD) begin
                    work_bin_d = score_clamped;
                    work_bcd_d = '0;
                    step_d     = '0;
                    state_d    = CONVERT;
                end
            end
            CONVERT: begin
                // LOAD is deliberately not looked at here.
                work_bcd_d = shifted[29:14];
                work_bin_d = shifted[13:0];
                step_d     = step_q + 4'd1;
                if (step_q == LAST_STEP) begin
                    // 14th shift: commit the finished digits in one go.
                    disp_d  = shifted[29:14];
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Free-running digit scanner; advances one digit per prescaler wrap.
    always_comb begin
        presc_d = presc_q + 1'b1;
        scan_d  = scan_q;
        if (presc_q == PRESC_MAX) begin
            presc_d = '0;
            scan_d  = scan_q + 2'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            state_q    <= IDLE;
            work_bin_q <= '0;
            work_bcd_q <= '0;
            step_q     <= '0;
            disp_q     <= '0;
            presc_q    <= '0;
            scan_q     <= '0;
            seg_q      <= '0;
            digit_q    <= '0;
            dot_q      <= 1'b1;
        end else begin
            state_q    <= state_d;
            work_bin_q <= work_bin_d;
            work_bcd_q <= work_bcd_d;
            step_q     <= step_d;
            disp_q     <= disp_d;
            presc_q    <= presc_d;
            scan_q     <= scan_d;
            // Select, digit and dot are all sampled from the same scan index
            // so they always change together.
            seg_q      <= scan_q;
            digit_q    <= disp_q[{scan_q, 2'b00} +: 4];
            dot_q      <= ~bus.DOT_MASK[scan_q];
        end
    end

    assign bus.BUSY           = (state_q == CONVERT);
    assign bus.SEG_SELECT_OUT = seg_q;
    assign bus.BIN_OUT        = digit_q;
    assign bus.DOT_OUT        = dot_q;

endmodule

// File: tb/tb_score_display_driver.sv
// tb_score_display_driver
//   Randomized and directed stimulus for score_display_driver (REFRESH_DIV = 4).
//   A reference model, written from the decimal rules of the block (clamped
//   integer score, 14-cycle busy window, digit = score / 10^i % 10, digit index
//   from elapsed cycles), pushes the expected outputs for every edge into a
//   queue; a monitor pops and compares at each falling edge.
module tb_score_display_driver;

    localparam int DIV = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    score_display_if bus ();

    score_display_driver #(.REFRESH_DIV(DIV)) dut (
        .CLK    (clk),
        .RESETN (rstn),
        .bus    (bus)
    );

    typedef struct {
        logic       busy;
        logic [1:0] seg;
        logic [3:0] bin;
        logic       dot;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    // ---------------- reference model ----------------
    bit m_valid = 0;
    int m_disp, m_pend, m_busy, m_t;
    int pow10[4] = '{1, 10, 100, 1000};

    always @(posedge clk) begin
        exp_t e;
        int   idx;
        if (!rstn) begin
            m_valid = 1;
            m_disp  = 0;
            m_busy  = 0;
            m_t     = 0;
            e.busy  = 0; e.seg = 0; e.bin = 0; e.dot = 1;
            sb.push_back(e);
        end else if (m_valid) begin
            idx   = (m_t / DIV) % 4;
            e.seg = 2'(idx);
            e.bin = 4'((m_disp / pow10[idx]) % 10);
            e.dot = ~bus.DOT_MASK[idx];
            if (m_busy > 0) begin
                m_busy--;
                if (m_busy == 0) m_disp = m_pend;
            end else if (bus.LOAD) begin
                m_pend = (int'(bus.SCORE_IN) > 9999) ? 9999 : int'(bus.SCORE_IN);
                m_busy = 14;
            end
            m_t++;
            e.busy = (m_busy > 0);
            sb.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("busy", 16'(bus.BUSY), 16'(e.busy));
            check("seg_select", 16'(bus.SEG_SELECT_OUT), 16'(e.seg));
            check("bin_out", 16'(bus.BIN_OUT), 16'(e.bin));
            check("dot_out", 16'(bus.DOT_OUT), 16'(e.dot));
            check("bin_le_9", 16'(bus.BIN_OUT <= 4'd9), 16'd1);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_pulse(input int score);
        bus.SCORE_IN = 14'(score);
        bus.LOAD     = 1'b1;
        tick(1);
        bus.LOAD     = 1'b0;
    endtask

    initial begin
        // reset with LOAD held high
        rstn         = 1'b0;
        bus.LOAD     = 1'b1;
        bus.SCORE_IN = 14'd4321;
        bus.DOT_MASK = 4'b0000;
        tick(2);
        rstn     = 1'b1;
        bus.LOAD = 1'b0;
        tick(5);

        // normal load and full scan cycle
        load_pulse(1234);
        tick(40);

        // saturation and zero
        load_pulse(12000);
        tick(35);
        load_pulse(0);
        tick(35);

        // load while busy: 5th and 14th busy cycles
        load_pulse(1234);
        tick(3);
        load_pulse(5678);
        tick(8);
        load_pulse(5678);
        tick(30);

        // reset during the 7th busy cycle
        load_pulse(5678);
        tick(5);
        rstn = 1'b0;
        tick(1);
        rstn = 1'b1;
        tick(40);

        // dot mask on digit 2
        bus.DOT_MASK = 4'b0100;
        load_pulse(9876);
        tick(40);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            bus.LOAD     = ($urandom_range(0, 5) == 0);
            bus.SCORE_IN = ($urandom_range(0, 1) == 0) ? 14'($urandom_range(0, 9999))
                                                       : 14'($urandom_range(0, 16383));
            if ($urandom_range(0, 15) == 0) bus.DOT_MASK = 4'($urandom);
            rstn = ($urandom_range(0, 249) != 0);
            tick(1);
        end
        rstn     = 1'b1;
        bus.LOAD = 1'b0;
        tick(20);
        #6;
        check("queue_drained", 16'(sb.size()), 16'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
